serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_pkg.sv | 12 +
 rtl/full_adder_cell.sv | 16 +
 rtl/serial_add_ctrl.sv | 107 ++++++++++
 tb/tb_serial_add_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial add/subtract controller.
package serial_add_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/full_adder_cell.sv
// One-bit combinational full adder; the only arithmetic in the serial datapath.
module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   logic p;

   assign p  = a ^ b;
   assign s  = p ^ ci;
   assign co = (a & b) | (ci & p);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor: one result bit per clock, LSB first, through a
// single full-adder cell and a one-bit carry register.
//
// state | meaning
// IDLE  | ready for a request; last result held on sum/cout/ovf
// RUN   | one operand bit pair added per edge, WIDTH edges total
// DONE  | result valid, held until the consumer takes it
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int               CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_res;
   logic [WIDTH-1:0] a_res_next;
   logic [WIDTH-1:0] b_shift;
   logic             carry;
   logic [CNT_W-1:0] bit_cnt;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             ovf_q;
   logic             fa_s;
   logic             fa_co;

   full_adder_cell u_fa (
      .a  (a_res[0]),
      .b  (b_shift[0]),
      .ci (carry),
      .s  (fa_s),
      .co (fa_co)
   );

   // Operand A drains out of the LSB while result bits fill in from the MSB,
   // so after WIDTH shifts the same register holds the full result.
   always_comb begin
      a_res_next            = a_res >> 1;
      a_res_next[WIDTH-1]   = fa_s;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         a_res   <= '0;
         b_shift <= '0;
         carry   <= 1'b0;
         bit_cnt <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_res   <= op_a;
                  b_shift <= op_b ^ {WIDTH{sub}};
                  carry   <= sub | cin;
                  bit_cnt <= '0;
                  state   <= RUN;
               end
            end
            RUN: begin
               a_res   <= a_res_next;
               b_shift <= b_shift >> 1;
               carry   <= fa_co;
               bit_cnt <= bit_cnt + CNT_W'(1);
               if (bit_cnt == LAST_BIT) begin
                  sum_q  <= a_res_next;
                  cout_q <= fa_co;
                  ovf_q  <= carry ^ fa_co;
                  state  <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8: directed table, DONE hold,
// mid-run reset and randomized operations against an arithmetic reference model.
module tb_serial_add_ctrl;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         cin;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   int checks   = 0;
   int failures = 0;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       c;
      logic       s;
      logic [7:0] es;
      logic       ec;
      logic       eo;
      string      name;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on unsigned and signed views.
   function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                 input logic c, input logic s,
                                 output logic [7:0] es, output logic ec, output logic eo);
      int ua, ub, sa, sb, u, r;
      ua = a;
      ub = b;
      sa = $signed(a);
      sb = $signed(b);
      if (s) begin
         u  = ua - ub;
         ec = (ua >= ub);
         r  = sa - sb;
      end else begin
         u  = ua + ub + int'(c);
         ec = (u > 255);
         r  = sa + sb + int'(c);
      end
      es = u[7:0];
      eo = (r > 127) || (r < -128);
   endfunction

   task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s,
                        input logic [7:0] es, input logic ec, input logic eo,
                        input int hold, input bit scramble, input string name);
      int lat;
      bit got;
      @(negedge clk);
      chk({name, "_in_ready_idle"}, in_ready, 1);
      in_valid  = 1'b1;
      op_a      = a;
      op_b      = b;
      cin       = c;
      sub       = s;
      out_ready = 1'b0;
      @(posedge clk);
      lat = 0;
      got = 0;
      while (!got && lat < 40) begin
         @(negedge clk);
         if (out_valid) begin
            got = 1;
         end else begin
            if (scramble) begin
               op_a     = 8'($urandom);
               op_b     = 8'($urandom);
               cin      = 1'($urandom);
               sub      = 1'($urandom);
               in_valid = 1'($urandom);
            end else begin
               in_valid = 1'b0;
            end
            @(posedge clk);
            lat++;
         end
      end
      in_valid = 1'b0;
      chk({name, "_latency"}, lat, W);
      chk({name, "_sum"}, sum, es);
      chk({name, "_cout"}, cout, ec);
      chk({name, "_ovf"}, ovf, eo);
      chk({name, "_in_ready_done"}, in_ready, 0);
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'b1;
         op_a     = 8'($urandom);
         op_b     = 8'($urandom);
         cin      = 1'($urandom);
         sub      = 1'($urandom);
         @(posedge clk);
         @(negedge clk);
         chk({name, "_hold_out_valid"}, out_valid, 1);
         chk({name, "_hold_in_ready"}, in_ready, 0);
         chk({name, "_hold_sum"}, {cout, ovf, sum}, {ec, eo, es});
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk({name, "_release_in_ready"}, in_ready, 1);
      chk({name, "_release_out_valid"}, out_valid, 0);
      chk({name, "_retain"}, {cout, ovf, sum}, {ec, eo, es});
   endtask

   initial begin
      logic [7:0] ra, rb, es;
      logic       rc, rs, ec, eo;
      int         seen;

      vecs[0] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, "add_0f_01"};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01"};
      vecs[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, "add_7f_01"};
      vecs[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, "sub_05_07"};
      vecs[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_80_01"};
      vecs[5] = '{8'h10, 8'h10, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, "sub_ignores_cin"};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      op_a      = '0;
      op_b      = '0;
      cin       = 1'b0;
      sub       = 1'b0;
      out_ready = 1'b0;

      #12;
      chk("reset_in_ready", in_ready, 1);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_outputs", {cout, ovf, sum}, 10'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
         do_op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].s,
               vecs[i].es, vecs[i].ec, vecs[i].eo, 0, (i % 2) == 1, vecs[i].name);
      end

      // DONE hold with in_valid asserted and operands changing.
      do_op(8'h55, 8'h2A, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, 5, 1'b1, "hold_55_2a");

      // Reset on the 4th RUN cycle aborts the operation.
      @(negedge clk);
      in_valid = 1'b1;
      op_a     = 8'h12;
      op_b     = 8'h34;
      cin      = 1'b0;
      sub      = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrun_reset_in_ready", in_ready, 1);
      chk("midrun_reset_out_valid", out_valid, 0);
      chk("midrun_reset_outputs", {cout, ovf, sum}, 10'h0);
      @(negedge clk);
      rst_n = 1'b1;
      seen  = 0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("midrun_reset_no_result", seen, 0);
      do_op(8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0, 0, 1'b0, "after_reset_03_04");

      for (int n = 0; n < 40; n++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rc = 1'($urandom);
         rs = 1'($urandom);
         if (n % 8 == 0) rb = ra;
         model(ra, rb, rc, rs, es, ec, eo);
         do_op(ra, rb, rc, rs, es, ec, eo, int'($urandom_range(0, 2)), 1'b1, $sformatf("rand%0d", n));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
